// File: rtl/bram_uart_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bram_uart_reader
// Purpose  : Streams a contiguous block of bytes from BRAM port B to a UART
//            transmitter, one byte at a time, using a tx_start/tx_busy
//            handshake. Launched by a one-cycle start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module bram_uart_reader #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] byte_to_send,
  output logic                  busy,
  output logic                  done
);

  // Latency counter only needs to hold 1..3.
  localparam int                c_lat_w     = 2;
  localparam logic [c_lat_w-1:0] c_lat_load = c_lat_w'(READ_LATENCY);
  localparam logic [c_lat_w-1:0] c_lat_one  = c_lat_w'(1);

  // Cycles spent in WAIT_ACK without seeing tx_busy before the byte is
  // assumed taken (covers a busy pulse too short to be observed).
  localparam logic [1:0] c_ack_last = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_rem_one = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   c_rem_zero = '0;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_READ      = 4'd2,
    S_WAIT_DATA = 4'd3,
    S_WAIT_IDLE = 4'd4,
    S_SEND      = 4'd5,
    S_WAIT_ACK  = 4'd6,
    S_WAIT_TX   = 4'd7,
    S_FINISH    = 4'd8
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [c_lat_w-1:0]    r_lat_cnt;
  logic [1:0]            r_ack_cnt;
  logic [DATA_WIDTH-1:0] r_byte;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_advance;
  logic                  w_last;

  assign w_last = (r_remaining == c_rem_one);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode, datapath strobes and Moore outputs.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    enb          = 1'b0;
    tx_start     = 1'b0;
    done         = 1'b0;
    busy         = (r_state != S_IDLE);
    addrb        = r_ptr;
    byte_to_send = r_byte;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_LOAD;
        end
      end
      // Length is checked once it sits in the counter.
      S_LOAD: begin
        w_next_state = (r_remaining == c_rem_zero) ? S_FINISH : S_READ;
      end
      S_READ: begin
        enb          = 1'b1;
        w_next_state = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (r_lat_cnt <= c_lat_one) begin
          w_capture    = 1'b1;
          w_next_state = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (!tx_busy) begin
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        tx_start     = 1'b1;
        w_next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          w_next_state = S_WAIT_TX;
        end else if (r_ack_cnt == c_ack_last) begin
          w_advance    = 1'b1;
          w_next_state = w_last ? S_FINISH : S_READ;
        end
      end
      S_WAIT_TX: begin
        if (!tx_busy) begin
          w_advance    = 1'b1;
          w_next_state = w_last ? S_FINISH : S_READ;
        end
      end
      S_FINISH: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Address pointer, byte count, timers and the outgoing byte register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_lat_cnt   <= '0;
      r_ack_cnt   <= '0;
      r_byte      <= '0;
    end else begin
      if (w_accept) begin
        r_ptr       <= base_addr;
        r_remaining <= length;
      end else if (w_advance) begin
        r_ptr       <= r_ptr + c_ptr_one;
        r_remaining <= r_remaining - c_rem_one;
      end

      if (r_state == S_READ) begin
        r_lat_cnt <= c_lat_load;
      end else if (r_state == S_WAIT_DATA && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - c_lat_one;
      end

      if (r_state == S_SEND) begin
        r_ack_cnt <= '0;
      end else if (r_state == S_WAIT_ACK && r_ack_cnt != c_ack_last) begin
        r_ack_cnt <= r_ack_cnt + 2'd1;
      end

      if (w_capture) begin
        r_byte <= doutb;
      end
    end
  end

endmodule
`default_nettype wire
